byte_port_arbiter: RTL and testbench
====================================

Name: byte_port_arbiter

Overview:
Arbitrates the 8-bit port B of the dual-port encrypted-image RAM between two requesters: requester 0 is the image loader/unloader and requester 1 is the processor byte-access unit.
- Round-robin grant, one access per cycle.
- Drives the RAM port B address, write-data and write-enable.
- Tracks in-flight reads through a latency-matched pipeline and returns each read byte to the requester that issued it.
- The 128-bit port A is untouched.

Parameters:
ADDR_W, 19, port B byte address width
DATA_W, 8, port B data width
READ_LATENCY, 2, clk edges from address sample to valid ram_q_b (legal 1..4)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 access request, held until gnt0
we0  in  1  requester 0 write (1) / read (0)
addr0  in  ADDR_W  requester 0 byte address
wdata0  in  DATA_W  requester 0 write byte
gnt0  out  1  requester 0 accepted this cycle
rvalid0  out  1  rdata0 valid, one-cycle pulse
rdata0  out  DATA_W  requester 0 read byte
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as the requester 0 ports, for requester 1
ram_address_b  out  ADDR_W  to RAM port B address
ram_data_b  out  DATA_W  to RAM port B write data
ram_wren_b  out  1  to RAM port B write enable
ram_q_b  in  DATA_W  from RAM port B read data

Behaviour:
Reset (rst_n low, asynchronous):
- last_grant=1, so requester 0 wins the first tie.
- Return pipeline valid bits cleared.
- rvalid0, rvalid1 = 0.
- Combinational outputs follow from the cleared state: gnt0/gnt1 depend only on req, and ram_wren_b=0 whenever there is no grant.
- Reads in flight when reset asserts are dropped and never returned.

Grant logic (combinational, same cycle as request):
- Only req0 high: gnt0=1.
- Only req1 high: gnt1=1.
- Both high: grant the requester not equal to last_grant.
- Neither high: no grant.
- gnt0 and gnt1 are never high together.
- A grant means the RAM samples that requester's access at the coming clk edge. The requester may change req/addr after that edge.
- last_grant updates on every edge with a grant. It holds otherwise.

RAM drive (combinational mux):
- Granted requester: ram_address_b=addrN, ram_data_b=wdataN, ram_wren_b=weN.
- No grant: ram_wren_b=0, ram_address_b=0, ram_data_b=0.

Return pipeline:
- Shift register, READ_LATENCY stages, each {valid, id}.
- Stage 0 loads valid = grant & ~we, id = granted requester.
- Stages advance every cycle with no stall; a read is accepted every cycle.
- Tail stage valid: rvalidID=1 and rdataID=ram_q_b, combinational from the tail stage.
- rdataN is 0 whenever rvalidN=0.
- Writes occupy no pipeline slot and produce no rvalid.

Ordering and throughput:
- Returns are strictly in issue order.
- Back-to-back reads from alternating requesters return on consecutive cycles with correct ids.
- Sustained throughput is 1 access/cycle.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1...; neither waits more than one cycle.

Hazards:
- Write followed by read of the same address on the next cycle returns the new data, per RAM port B read-after-write.
- The arbiter does no forwarding.
- Port A/port B collisions are outside this block.

Test Plan:
- Reset then req0 read addr=4 for one cycle -> gnt0=1 same cycle; ram_address_b=4, ram_wren_b=0; rvalid0=1 exactly 2 edges later with rdata0=RAM[4]; rvalid1 never asserts.
- req1 write addr=2 data=99 (8'd99), then req1 read addr=2 next cycle -> ram_wren_b=1 only during the write cycle; read returns rvalid1 with rdata1=99; the write produces no rvalid.
- req0 and req1 both held high for 6 cycles, reads at addr 10 and 20 -> grants 0,1,0,1,0,1; rvalid0/rvalid1 alternate starting 2 cycles after the first grant with data RAM[10]/RAM[20].
- Both requesting after a lone req1 grant -> requester 0 wins the tie; after a lone req0 grant -> requester 1 wins.
- Issue reads on consecutive cycles, assert rst_n=0 for one cycle between issue and return -> no rvalid pulses for the dropped reads; after release, first tie goes to requester 0.
- Idle cycles (no req) -> ram_wren_b=0, ram_address_b=0, gnt0=gnt1=0; repeat a single read with READ_LATENCY=1 and 4 -> rvalid at exactly 1 and 4 edges.

Source files
------------

// File: rtl/byte_port_arbiter_if.sv
// rtl/byte_port_arbiter_if.sv - requester and RAM port B signal bundle for byte_port_arbiter
interface byte_port_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    // requester 0: image loader/unloader
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    // requester 1: processor byte-access unit
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    // RAM port B
    logic [ADDR_W-1:0] ram_address_b;
    logic [DATA_W-1:0] ram_data_b;
    logic              ram_wren_b;
    logic [DATA_W-1:0] ram_q_b;

    // arbiter side
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ram_q_b,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output ram_address_b, ram_data_b, ram_wren_b
    );

    // requesters plus RAM side
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ram_q_b,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  ram_address_b, ram_data_b, ram_wren_b
    );
endinterface

// File: rtl/byte_port_arbiter.sv
// rtl/byte_port_arbiter.sv - round-robin arbiter for the 8-bit RAM port B with read return routing
module byte_port_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    byte_port_arbiter_if.slave bus
);
    // last_grant: id of the requester that won the most recent grant
    logic                    last_grant;
    logic                    gnt0_c;
    logic                    gnt1_c;
    logic                    grant_any;
    logic                    grant_id;
    logic                    grant_we;

    // return pipeline: one {valid, id} slot per RAM latency edge
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_id;
    logic                    tail_valid;
    logic                    tail_id;
    logic                    rvalid0_c;
    logic                    rvalid1_c;

    // Round-robin pick: a lone request always wins, a tie goes to the requester that did not win last
    always_comb begin
        gnt0_c    = bus.req0 & (~bus.req1 | last_grant);
        gnt1_c    = bus.req1 & (~bus.req0 | ~last_grant);
        grant_any = gnt0_c | gnt1_c;
        grant_id  = gnt1_c;
        grant_we  = gnt1_c ? bus.we1 : (gnt0_c & bus.we0);
    end

    // Port B mux; everything forced to zero when idle so no stray write can reach the RAM
    always_comb begin
        bus.ram_address_b = '0;
        bus.ram_data_b    = '0;
        bus.ram_wren_b    = 1'b0;
        if (gnt0_c) begin
            bus.ram_address_b = bus.addr0;
            bus.ram_data_b    = bus.wdata0;
            bus.ram_wren_b    = bus.we0;
        end else if (gnt1_c) begin
            bus.ram_address_b = bus.addr1;
            bus.ram_data_b    = bus.wdata1;
            bus.ram_wren_b    = bus.we1;
        end
    end

    // Grants are presented in the same cycle as the request
    always_comb begin
        bus.gnt0 = gnt0_c;
        bus.gnt1 = gnt1_c;
    end

    // Fairness state and read-tracking shift register; reset drops every read in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            pipe_valid <= '0;
            pipe_id    <= '0;
        end else begin
            if (grant_any) begin
                last_grant <= grant_id;
            end
            pipe_valid[0] <= grant_any & ~grant_we;
            pipe_id[0]    <= grant_id;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_id[i]    <= pipe_id[i-1];
            end
        end
    end

    // Tail slot lines up with ram_q_b; steer the byte to its issuer and zero the other data bus
    always_comb begin
        tail_valid  = pipe_valid[READ_LATENCY-1];
        tail_id     = pipe_id[READ_LATENCY-1];
        rvalid0_c   = tail_valid & ~tail_id;
        rvalid1_c   = tail_valid & tail_id;
        bus.rvalid0 = rvalid0_c;
        bus.rvalid1 = rvalid1_c;
        bus.rdata0  = rvalid0_c ? bus.ram_q_b : '0;
        bus.rdata1  = rvalid1_c ? bus.ram_q_b : '0;
    end
endmodule

// File: tb/tb_byte_port_arbiter.sv
// tb/tb_byte_port_arbiter.sv - table and scoreboard bench for byte_port_arbiter at read latencies 2, 1 and 4
module tb_byte_port_arbiter;
    localparam int AW = 19;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    byte_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    byte_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();
    byte_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_c ();

    byte_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    byte_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
    byte_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

    // the three DUTs see identical requester stimulus
    assign bus_b.req0 = bus_a.req0;   assign bus_c.req0 = bus_a.req0;
    assign bus_b.we0  = bus_a.we0;    assign bus_c.we0  = bus_a.we0;
    assign bus_b.addr0 = bus_a.addr0; assign bus_c.addr0 = bus_a.addr0;
    assign bus_b.wdata0 = bus_a.wdata0; assign bus_c.wdata0 = bus_a.wdata0;
    assign bus_b.req1 = bus_a.req1;   assign bus_c.req1 = bus_a.req1;
    assign bus_b.we1  = bus_a.we1;    assign bus_c.we1  = bus_a.we1;
    assign bus_b.addr1 = bus_a.addr1; assign bus_c.addr1 = bus_a.addr1;
    assign bus_b.wdata1 = bus_a.wdata1; assign bus_c.wdata1 = bus_a.wdata1;

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    // RAM models: contents reload while reset is low, read data appears READ_LATENCY edges after the address
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] mem_c [256];
    logic [7:0] q_a [2];
    logic [7:0] q_b;
    logic [7:0] q_c [4];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_val(i);
        end else if (bus_a.ram_wren_b) begin
            mem_a[bus_a.ram_address_b[7:0]] <= bus_a.ram_data_b;
        end
        q_a[0] <= mem_a[bus_a.ram_address_b[7:0]];
        q_a[1] <= q_a[0];
    end
    assign bus_a.ram_q_b = q_a[1];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= init_val(i);
        end else if (bus_b.ram_wren_b) begin
            mem_b[bus_b.ram_address_b[7:0]] <= bus_b.ram_data_b;
        end
        q_b <= mem_b[bus_b.ram_address_b[7:0]];
    end
    assign bus_b.ram_q_b = q_b;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem_c[i] <= init_val(i);
        end else if (bus_c.ram_wren_b) begin
            mem_c[bus_c.ram_address_b[7:0]] <= bus_c.ram_data_b;
        end
        q_c[0] <= mem_c[bus_c.ram_address_b[7:0]];
        for (int i = 1; i < 4; i++) q_c[i] <= q_c[i-1];
    end
    assign bus_c.ram_q_b = q_c[3];

    typedef struct {
        logic       rst;
        logic       r0, w0;
        logic [7:0] a0, d0;
        logic       r1, w1;
        logic [7:0] a1, d1;
        logic       eg0, eg1, ewe;
        logic [7:0] ea, ed;
    } vec_t;

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         due;
    } ret_t;

    vec_t       tbl [$];
    ret_t       sb [3][$];
    int         lat [3];
    logic [7:0] ref_mem [256];
    int         cyc;
    int         n_checks;
    int         n_fail;

    function automatic vec_t mk(input logic rst, input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                                input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                                input logic eg0, input logic eg1, input logic ewe, input logic [7:0] ea, input logic [7:0] ed);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe; v.ea = ea; v.ed = ed;
        return v;
    endfunction

    task automatic init_ref();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_comb(input int k, input logic g0, input logic g1, input logic we,
                            input logic [AW-1:0] addr, input logic [7:0] data, input vec_t v);
        chk($sformatf("L%0d gnt0", lat[k]), 32'(g0), 32'(v.eg0));
        chk($sformatf("L%0d gnt1", lat[k]), 32'(g1), 32'(v.eg1));
        chk($sformatf("L%0d ram_wren_b", lat[k]), 32'(we), 32'(v.ewe));
        chk($sformatf("L%0d ram_address_b", lat[k]), 32'(addr), 32'(v.ea));
        chk($sformatf("L%0d ram_data_b", lat[k]), 32'(data), 32'(v.ed));
    endtask

    task automatic chk_ret(input int k, input logic rv0, input logic [7:0] rd0, input logic rv1, input logic [7:0] rd1);
        logic       e0, e1;
        logic [7:0] d0, d1;
        ret_t       r;
        e0 = 1'b0; e1 = 1'b0; d0 = 8'd0; d1 = 8'd0;
        while (sb[k].size() > 0 && sb[k][0].due < cyc) void'(sb[k].pop_front());
        if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
            r = sb[k].pop_front();
            if (r.id) begin e1 = 1'b1; d1 = r.data; end
            else      begin e0 = 1'b1; d0 = r.data; end
        end
        chk($sformatf("L%0d rvalid0", lat[k]), 32'(rv0), 32'(e0));
        chk($sformatf("L%0d rdata0", lat[k]), 32'(rd0), 32'(d0));
        chk($sformatf("L%0d rvalid1", lat[k]), 32'(rv1), 32'(e1));
        chk($sformatf("L%0d rdata1", lat[k]), 32'(rd1), 32'(d1));
    endtask

    task automatic drive(input vec_t v);
        rst_n        = ~v.rst;
        bus_a.req0   = v.r0;
        bus_a.we0    = v.w0;
        bus_a.addr0  = AW'(v.a0);
        bus_a.wdata0 = v.d0;
        bus_a.req1   = v.r1;
        bus_a.we1    = v.w1;
        bus_a.addr1  = AW'(v.a1);
        bus_a.wdata1 = v.d1;
    endtask

    // one clock cycle: drive after the edge, check at the falling edge, record the expected read return
    task automatic step(input vec_t v);
        logic       we;
        logic [7:0] ga;
        drive(v);
        if (v.rst) begin
            for (int k = 0; k < 3; k++) sb[k].delete();
            init_ref();
        end
        @(negedge clk);
        chk_comb(0, bus_a.gnt0, bus_a.gnt1, bus_a.ram_wren_b, bus_a.ram_address_b, bus_a.ram_data_b, v);
        chk_comb(1, bus_b.gnt0, bus_b.gnt1, bus_b.ram_wren_b, bus_b.ram_address_b, bus_b.ram_data_b, v);
        chk_comb(2, bus_c.gnt0, bus_c.gnt1, bus_c.ram_wren_b, bus_c.ram_address_b, bus_c.ram_data_b, v);
        chk_ret(0, bus_a.rvalid0, bus_a.rdata0, bus_a.rvalid1, bus_a.rdata1);
        chk_ret(1, bus_b.rvalid0, bus_b.rdata0, bus_b.rvalid1, bus_b.rdata1);
        chk_ret(2, bus_c.rvalid0, bus_c.rdata0, bus_c.rvalid1, bus_c.rdata1);
        if (!v.rst && (v.eg0 || v.eg1)) begin
            we = v.eg0 ? v.w0 : v.w1;
            ga = v.eg0 ? v.a0 : v.a1;
            if (!we) begin
                for (int k = 0; k < 3; k++) sb[k].push_back('{id: v.eg1, data: ref_mem[ga], due: cyc + lat[k]});
            end else begin
                ref_mem[ga] = v.eg0 ? v.d0 : v.d1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        logic first1;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        lat[0] = 2; lat[1] = 1; lat[2] = 4;
        init_ref();
        idle = mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0);
        v = idle; v.rst = 1'b1;
        drive(v);

        //            rst r0 w0 a0  d0   r1 w1 a1  d1   eg0 eg1 ewe ea  ed
        tbl.push_back(mk(1, 0,0,0,0,     0,0,0,0,      0,0,0,0,0));
        tbl.push_back(mk(1, 0,0,0,0,     0,0,0,0,      0,0,0,0,0));
        tbl.push_back(mk(0, 1,0,4,0,     0,0,0,0,      1,0,0,4,0));
        tbl.push_back(idle);
        tbl.push_back(idle);
        tbl.push_back(mk(0, 0,0,0,0,     1,1,2,99,     0,1,1,2,99));
        tbl.push_back(mk(0, 0,0,0,0,     1,0,2,55,     0,1,0,2,55));
        tbl.push_back(idle);
        tbl.push_back(idle);
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk(0, 1,0,10,0, 1,0,20,0,    1,0,0,10,0));
            tbl.push_back(mk(0, 1,0,10,0, 1,0,20,0,    0,1,0,20,0));
        end
        tbl.push_back(mk(0, 1,0,5,0,     0,0,0,0,      1,0,0,5,0));
        tbl.push_back(mk(0, 1,0,6,0,     1,0,7,0,      0,1,0,7,0));
        tbl.push_back(mk(0, 0,0,0,0,     1,0,8,0,      0,1,0,8,0));
        tbl.push_back(mk(0, 1,0,9,0,     1,0,11,0,     1,0,0,9,0));
        tbl.push_back(idle);
        tbl.push_back(idle);
        tbl.push_back(mk(0, 0,0,0,0,     1,0,12,0,     0,1,0,12,0));
        tbl.push_back(mk(0, 1,0,13,0,    0,0,0,0,      1,0,0,13,0));
        tbl.push_back(mk(1, 0,0,0,0,     0,0,0,0,      0,0,0,0,0));
        tbl.push_back(mk(0, 1,0,14,0,    1,0,15,0,     1,0,0,14,0));
        for (int i = 0; i < 5; i++) tbl.push_back(idle);
        tbl.push_back(mk(0, 1,1,3,8'hA5, 0,0,0,0,      1,0,1,3,8'hA5));
        tbl.push_back(mk(0, 1,0,3,8'h3C, 0,0,0,0,      1,0,0,3,8'h3C));
        for (int i = 0; i < 5; i++) tbl.push_back(idle);

        @(posedge clk);
        #1;
        foreach (tbl[i]) step(tbl[i]);

        // continuous contention: last winner was requester 0, so grants must go 1,0,1,0...
        first1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = mk(0, 1,0,8'(40+i),0, 1,0,8'(60+i),0, 0,0,0,0,0);
            v.eg1 = first1 ^ 1'(i % 2);
            v.eg0 = ~v.eg1;
            v.ea  = v.eg1 ? 8'(60+i) : 8'(40+i);
            step(v);
        end
        for (int i = 0; i < 6; i++) step(idle);

        for (int k = 0; k < 3; k++) chk($sformatf("L%0d returns outstanding", lat[k]), 32'(sb[k].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
